// File: rtl/dm_pkg.sv
// Shared definitions for the byte-writable data memory: access-mode
// encodings, fault codes, controller states and the alignment rule.
package dm_pkg;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_HU = 3'd2;
    localparam logic [2:0] DM_B  = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_RANGE    = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dm_state_e;

    // Natural alignment per access size; unknown modes are treated as
    // misaligned so they fault instead of touching the array.
    function automatic logic dm_aligned(input logic [2:0] op, input logic [1:0] off);
        logic ok;
        case (op)
            DM_W:        ok = (off == 2'b00);
            DM_H, DM_HU: ok = (off[0] == 1'b0);
            DM_B, DM_BU: ok = 1'b1;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Expand a 4-bit byte-lane mask into a 32-bit bit mask.
    function automatic logic [31:0] dm_lane_bits(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// Combinational byte-lane steering: store-side lane mask and lane-aligned
// write data, load-side sub-word extraction with sign/zero extension.
module dm_byte_lane
    import dm_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wd,
    input  logic [31:0] word,
    output logic [3:0]  lane_mask,
    output logic [31:0] lane_wd,
    output logic [31:0] rd
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Store side: which lanes are written and the replicated write data.
    always_comb begin
        lane_mask = 4'b0000;
        lane_wd   = 32'h0000_0000;
        case (op)
            DM_W: begin
                lane_mask = 4'b1111;
                lane_wd   = wd;
            end
            DM_H, DM_HU: begin
                if (off[1]) begin
                    lane_mask = 4'b1100;
                end else begin
                    lane_mask = 4'b0011;
                end
                lane_wd = {wd[15:0], wd[15:0]};
            end
            DM_B, DM_BU: begin
                lane_mask = 4'b0001 << off;
                lane_wd   = {4{wd[7:0]}};
            end
            default: begin
                lane_mask = 4'b0000;
                lane_wd   = 32'h0000_0000;
            end
        endcase
    end

    // Load side: pick the addressed half-word/byte and extend per mode.
    always_comb begin
        half_s = 16'h0000;
        byte_s = 8'h00;
        rd     = 32'h0000_0000;
        if (off[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (off)
            2'b00:   byte_s = word[7:0];
            2'b01:   byte_s = word[15:8];
            2'b10:   byte_s = word[23:16];
            2'b11:   byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        case (op)
            DM_W:    rd = word;
            DM_H:    rd = {{16{half_s[15]}}, half_s};
            DM_HU:   rd = {16'h0000, half_s};
            DM_B:    rd = {{24{byte_s[7]}}, byte_s};
            DM_BU:   rd = {24'h00_0000, byte_s};
            default: rd = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_bw.sv
// MEM-stage data memory with sub-word access, configurable depth/base,
// post-reset clear sweep and registered misalign/out-of-range fault pulse.
module data_mem_bw
    import dm_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          LOG_EN    = 1'b1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic [2:0]  op,
    output logic [31:0] rd,
    output logic        busy,
    output logic        exc,
    output logic [1:0]  exc_code
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    logic [31:0]       mem_r [DEPTH];

    dm_state_e         state_r, state_n;
    logic [ADDR_W-1:0] ptr_r, ptr_n;
    logic              busy_r, busy_n;
    logic              exc_r, exc_n;
    logic [1:0]        exc_code_r, exc_code_n;

    logic [31:0]       offs_s;
    logic [ADDR_W-1:0] idx_s;
    logic              in_range_s;
    logic              aligned_s;
    logic              access_s;
    logic              fault_s;
    logic              store_ok_s;
    logic [31:0]       word_s;
    logic [3:0]        lane_mask_s;
    logic [31:0]       lane_wd_s;
    logic [31:0]       lane_rd_s;
    logic [31:0]       merged_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_idx_s;
    logic [31:0]       wr_data_s;

    assign offs_s = addr - BASE_ADDR;
    assign idx_s  = offs_s[ADDR_W+1:2];
    assign word_s = mem_r[idx_s];

    // Address decode: range, alignment, whether this cycle is an access.
    // Idle slots (load word from address 0) are never faulted.
    always_comb begin
        in_range_s = (addr >= BASE_ADDR) && ((offs_s >> (ADDR_W + 2)) == 32'h0000_0000);
        aligned_s  = dm_aligned(op, addr[1:0]);
        access_s   = we || (op != DM_W) || (addr != 32'h0000_0000);
        fault_s    = access_s && !(in_range_s && aligned_s);
        store_ok_s = (state_r == ST_READY) && we && in_range_s && aligned_s;
    end

    dm_byte_lane u_lane (
        .op        (op),
        .off       (addr[1:0]),
        .wd        (wd),
        .word      (word_s),
        .lane_mask (lane_mask_s),
        .lane_wd   (lane_wd_s),
        .rd        (lane_rd_s)
    );

    assign merged_s = (word_s & ~dm_lane_bits(lane_mask_s))
                    | (lane_wd_s & dm_lane_bits(lane_mask_s));

    // Load data is suppressed while clearing and for any faulting address.
    always_comb begin
        rd = 32'h0000_0000;
        if (busy_r || !in_range_s || !aligned_s) begin
            rd = 32'h0000_0000;
        end else begin
            rd = lane_rd_s;
        end
    end

    // Single write port shared by the clear sweep and normal stores.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = ptr_r;
        wr_data_s = 32'h0000_0000;
        if (state_r == ST_CLEAR) begin
            wr_en_s   = reset;
            wr_idx_s  = ptr_r;
            wr_data_s = 32'h0000_0000;
        end else begin
            wr_en_s   = store_ok_s;
            wr_idx_s  = idx_s;
            wr_data_s = merged_s;
        end
    end

    // Storage array; contents are initialised by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Controller next state: sweep pointer, busy flag and fault capture.
    always_comb begin
        state_n    = state_r;
        ptr_n      = ptr_r;
        busy_n     = busy_r;
        exc_n      = 1'b0;
        exc_code_n = EXC_NONE;
        case (state_r)
            ST_CLEAR: begin
                if (ptr_r == PTR_LAST) begin
                    state_n = ST_READY;
                    busy_n  = 1'b0;
                end else begin
                    ptr_n  = ptr_r + PTR_ONE;
                    busy_n = 1'b1;
                end
            end
            ST_READY: begin
                busy_n = 1'b0;
                if (fault_s) begin
                    exc_n = 1'b1;
                    if (!in_range_s) begin
                        exc_code_n = EXC_RANGE;
                    end else begin
                        exc_code_n = EXC_MISALIGN;
                    end
                end else begin
                    exc_n      = 1'b0;
                    exc_code_n = EXC_NONE;
                end
            end
            default: begin
                state_n = ST_CLEAR;
                ptr_n   = {ADDR_W{1'b0}};
                busy_n  = 1'b1;
            end
        endcase
    end

    // Controller state register; reset restarts the sweep from word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_CLEAR;
            ptr_r      <= {ADDR_W{1'b0}};
            busy_r     <= 1'b1;
            exc_r      <= 1'b0;
            exc_code_r <= EXC_NONE;
        end else begin
            state_r    <= state_n;
            ptr_r      <= ptr_n;
            busy_r     <= busy_n;
            exc_r      <= exc_n;
            exc_code_r <= exc_code_n;
        end
    end

    assign busy     = busy_r;
    assign exc      = exc_r;
    assign exc_code = exc_code_r;

`ifndef SYNTHESIS
    // Simulation trace of every committed store with the merged word.
    always_ff @(posedge clk) begin
        if (LOG_EN && reset && store_ok_s) begin
            $write("@%h: *%h <= %h\n", pc, {addr[31:2], 2'b00}, merged_s);
        end
    end
`endif

endmodule

// File: doc/data_mem_bw.md
# data_mem_bw

Parametrised word-organised data memory for the MIPS datapath, the next-generation DM. Adds sub-word stores and loads (sb/sh/sw, lb/lbu/lh/lhu/lw), a configurable depth and base address, a self-clearing sweep after reset, and registered exception reporting for misaligned and out-of-range accesses. Sits in the MEM stage between the ALU result/rt data and the write-back mux.

## Interface

Parameters:
- `ADDR_W`, 10: word-address width; depth = 2^ADDR_W words of 32 bits.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `LOG_EN`, 1: emit the simulation write log.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc`  in  32  PC of the accessing instruction; used only by the log.
- `addr`  in  32  byte address.
- `wd`  in  32  store data; the low byte or half-word is used for sb/sh.
- `we`  in  1  store enable.
- `op`  in  3  access mode, encoded in the package: `W`, `H`, `HU`, `B`, `BU`.
- `rd`  out  32  load data, extended per `op`.
- `busy`  out  1  clear sweep in progress.
- `exc`  out  1  registered one-cycle fault pulse.
- `exc_code`  out  2  `00` none, `01` misaligned, `10` out of range; valid while `exc`=1.

## Operation

- Word index = (`addr` − `BASE_ADDR`) >> 2.
  - The access is in range iff `addr` ≥ `BASE_ADDR` and the index < 2^ADDR_W.
- Alignment rules:
  - `W` requires `addr[1:0]`=0.
  - `H`/`HU` require `addr[0]`=0.
  - `B`/`BU` are always aligned.
- Store (`we`=1, not `busy`, in range, aligned): on the edge, update only the byte lanes selected by `op` and `addr[1:0]`.
  - sb at offset k writes `wd[7:0]` into byte k, where byte 0 = bits [7:0].
  - sh at offset 2 writes `wd[15:0]` into bits [31:16].
- Load: combinational from the current array contents.
  - Select the byte or half-word at `addr[1:0]`.
  - `B`/`H` sign-extend; `BU`/`HU` zero-extend.
  - `rd`=0 when `busy`, when out of range, or when misaligned.
- Fault: an access that is misaligned or out of range raises `exc` for the following cycle. A faulting store writes nothing.
  - An access counts for this purpose when `we`=1, or when `op`≠`W`, or when `addr`≠0.
  - If both faults apply, out of range wins (`10`).
- FSM states are `CLEAR` and `READY`.
  - Reset (`reset`=0) asynchronously forces `CLEAR`, sets the sweep pointer to 0, `busy`=1, `exc`=0, `exc_code`=0.
  - In `CLEAR`, each edge with `reset`=1 zeroes the word at the pointer, then increments the pointer.
  - When the pointer reaches 2^ADDR_W−1 and that word is written, go to `READY` and set `busy`=0.
  - While `busy`=1, stores are ignored and no faults are reported.
- Log: when `LOG_EN` is set, each successful store prints `@%h: *%h <= %h` with `pc`, the word-aligned byte address, and the merged 32-bit word. This is simulation-only and has no hardware effect.

## Timing

- Store latency 1: the data is visible on `rd` in the cycle after the edge.
  - A load from the same address in the store cycle returns the old value.
- Load latency 0 (combinational).
- Clear sweep takes exactly 2^ADDR_W cycles after `reset` deasserts. `busy` falls on the final sweep edge.
- Reset asserted mid-sweep or mid-operation restarts the sweep from word 0.
- `exc` is asserted for exactly one cycle per faulting access. Back-to-back faults keep `exc` high, with `exc_code` updated every cycle.
- Pointer does not wrap: it stays at its final value in `READY`.

## Structure

- Package `dm_pkg` holds:
  - `op` encodings (`DM_W=0`, `DM_H=1`, `DM_HU=2`, `DM_B=3`, `DM_BU=4`).
  - `exc_code` constants.
  - The FSM state typedef.
- Sub-module `dm_byte_lane` is combinational and does two jobs:
  - Store side: builds the 4-bit lane mask and the lane-aligned write data from `op`, `addr[1:0]` and `wd`.
  - Load side: extracts and extends `rd`.
- Top level contains the array, the FSM, the sweep pointer, the fault register and the log.

## Test plan

- Reset pulse low for 2 cycles with `ADDR_W`=4, then release → `busy`=1 for exactly 16 cycles; every word then reads 0.
- sw 32'h1234_5678 @0, then sb 8'hAB @1, then lb @1 and lbu @1 → word = 32'h1234_AB78; `rd` = 32'hFFFF_FFAB, then 32'h0000_00AB.
- sh 16'h8001 @6, then lh @6 and lhu @6 → `rd` = 32'hFFFF_8001, then 32'h0000_8001; bits [15:0] of word 1 are unchanged.
- sw @2 (misaligned) → no write, `exc`=1 with `exc_code`=01 for one cycle. sw @(BASE_ADDR + 4·2^ADDR_W) → `exc_code`=10, `rd`=0.
- Store attempted while `busy`=1 → ignored, `exc`=0; the word reads 0 after the sweep.
- Reset asserted at sweep cycle 7 after prior writes → sweep restarts, takes a full 2^ADDR_W cycles, and all words read 0.
